fsm_launcher: RTL and testbench
===============================

Name: fsm_launcher

Overview:
- Initiator side of the start/busy/done handshake used by `fsm_example`-style worker FSMs.
- Accepts a job request (a count of launches) over valid/ready.
- Issues single-cycle start pulses to the worker, one per launch, waiting for each done before the next.
- Guards each launch with a watchdog and returns a response carrying the launch count, total cycles and a timeout flag.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT_DONE per launch before abort; legal range ≥2.
- N_W, 8: width of the launch-count request and the jobs-done response.
- CYC_W, 16: width of the cycle counter; saturating.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; high only in IDLE.
- req_count_i  in  N_W  number of launches; sampled on the accept cycle.
- start_o  out  1  start pulse to worker.
- busy_i  in  1  worker busy.
- done_i  in  1  worker done pulse.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_jobs_o  out  N_W  launches completed with done.
- rsp_cycles_o  out  CYC_W  cycles from first START cycle through last counted cycle.
- rsp_timeout_o  out  1  1 = a launch timed out, run aborted.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low, on rst_ni.
- Reset values: state=IDLE, req_ready_o=1, start_o=0, rsp_valid_o=0, rsp_jobs_o=0, rsp_cycles_o=0, rsp_timeout_o=0. Watchdog and internal counters are cleared.
- Reset asserted mid-operation:
  - start_o and rsp_valid_o drop immediately (asynchronously).
  - The in-flight job is discarded; no response is produced.
- States: IDLE, START, WAIT_DONE, GAP, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch req_count_i and clear jobs and cycles.
  - If count==0, go to RESP with jobs=0, cycles=0, timeout=0; otherwise go to START.
- START:
  - start_o = (state==START) && !busy_i, combinational.
  - While busy_i=1, start_o stays 0 and the FSM stalls in START; stall cycles are counted in cycles.
  - On the cycle start_o=1, go to WAIT_DONE with watchdog=0.
  - start_o is never high for 2 consecutive cycles.
- WAIT_DONE:
  - done_i=1: jobs+=1. If jobs+1==count go to RESP, else go to GAP.
  - Otherwise, if watchdog==TIMEOUT_CYCLES-1, set timeout=1 and go to RESP.
  - Otherwise watchdog+=1.
  - done_i has priority over timeout when both occur in the same cycle.
- GAP: one idle cycle (start_o=0), counted in cycles, then START.
- done_i outside WAIT_DONE is ignored and does not change jobs.
- Cycle counter:
  - Increments on every cycle spent in START, WAIT_DONE or GAP, including the final done/timeout cycle.
  - Saturates at 2^CYC_W-1; no wrap.
  - Single launch, done_i k cycles after the start_o cycle, no stall: cycles = k+1.
- RESP:
  - rsp_valid_o=1 with rsp_* stable.
  - Held until rsp_ready_i=1; on that cycle go to IDLE.
  - req_ready_o=0 during RESP, so a new request is accepted no earlier than the cycle after the handshake.
- Outputs: rsp_* are registered. Only start_o is combinational.

Test Plan:
- Basic launch: reset 3 cycles; request count=1; worker model pulses done_i 6 cycles after start, busy_i=1 in between; rsp_ready_i=1. Required: one start_o pulse, 1 cycle after accept; rsp jobs=1, cycles=7, timeout=0.
- Multi-launch: count=3, worker done at k=6 each. Required:
  - 3 start pulses spaced 8 cycles apart (START + 6 wait + GAP).
  - rsp jobs=3, cycles=23; start_o never asserted while busy_i=1.
- Busy stall: busy_i forced 1 for 4 cycles after entering START, then worker done at k=6. Required: start_o delayed 4 cycles; cycles=11.
- Timeout: TIMEOUT_CYCLES=8, worker never asserts done_i. Required: rsp timeout=1, jobs=0, cycles=9. Also done_i exactly at watchdog=7 yields timeout=0, jobs=1.
- Zero count and backpressure: count=0 gives rsp jobs=0, cycles=0. Hold rsp_ready_i=0 for 5 cycles. Required: rsp_valid_o and rsp_* stable; req_ready_o=0 until the cycle after the handshake.
- Reset mid-run: assert rst_ni low during WAIT_DONE of job 2 of count=3. Required:
  - All outputs at reset values immediately; no response.
  - A fresh count=1 request afterwards completes normally.

Source files
------------

// File: rtl/fsm_launcher.sv
// ============================================================================
// fsm_launcher
// ----------------------------------------------------------------------------
// Initiator side of a start/busy/done handshake towards a worker FSM.
// A job request (a launch count) is accepted over valid/ready. For each launch
// a single-cycle start pulse is issued to the worker, then the launcher waits
// for the worker's done pulse before the next launch. Each launch is guarded
// by a watchdog. When the job finishes, or a launch times out, a response
// carrying jobs completed, elapsed cycles and a timeout flag is presented
// over valid/ready.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request valid
//   req_ready_o    request ready (high only in IDLE)
//   req_count_i    number of launches, sampled on the accept cycle
//   start_o        start pulse to the worker (combinational)
//   busy_i         worker busy
//   done_i         worker done pulse
//   rsp_valid_o    response valid
//   rsp_ready_i    response ready
//   rsp_jobs_o     launches that completed with done
//   rsp_cycles_o   cycles spent in START/WAIT_DONE/GAP (saturating)
//   rsp_timeout_o  a launch timed out and the run was aborted
// ============================================================================
module fsm_launcher #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int N_W            = 8,
    parameter int CYC_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [N_W-1:0]   req_count_i,
    output logic             start_o,
    input  logic             busy_i,
    input  logic             done_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [N_W-1:0]   rsp_jobs_o,
    output logic [CYC_W-1:0] rsp_cycles_o,
    output logic             rsp_timeout_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [N_W-1:0]    count_q, count_d;
    logic [N_W-1:0]    jobs_q, jobs_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
    logic [N_W-1:0]    jobs_inc;

    assign jobs_inc = jobs_q + 1'b1;

    // Outputs are decoded straight from registered state, so the async reset
    // clears them immediately. Only start_o also depends on an input.
    assign req_ready_o   = (state_q == S_IDLE);
    assign start_o       = (state_q == S_START) && !busy_i;
    assign rsp_valid_o   = (state_q == S_RESP);
    assign rsp_jobs_o    = jobs_q;
    assign rsp_cycles_o  = cycles_q;
    assign rsp_timeout_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        jobs_d    = jobs_q;
        cycles_d  = cycles_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;

        // Every active cycle is counted, including the final done/timeout
        // cycle; the counter sticks at all-ones rather than wrapping.
        if ((state_q == S_START || state_q == S_WAIT_DONE || state_q == S_GAP)
            && (cycles_q != CYC_MAX)) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    count_d   = req_count_i;
                    jobs_d    = '0;
                    cycles_d  = '0;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = (req_count_i == '0) ? S_RESP : S_START;
                end
            end
            S_START: begin
                // Stall while the worker is still busy; launch otherwise.
                if (!busy_i) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // done wins over a watchdog expiry in the same cycle.
                if (done_i) begin
                    jobs_d  = jobs_inc;
                    state_d = (jobs_inc == count_q) ? S_RESP : S_GAP;
                end else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_GAP: begin
                // One idle cycle keeps start pulses from being back to back.
                state_d = S_START;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            jobs_q    <= '0;
            cycles_q  <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            jobs_q    <= jobs_d;
            cycles_q  <= cycles_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fsm_launcher.sv
// ============================================================================
// tb_fsm_launcher
// ----------------------------------------------------------------------------
// Directed bench for fsm_launcher. A worker model answers start pulses with a
// busy stretch and a done pulse; a monitor logs start pulses. Expected
// responses are queued when a request is issued and compared when the
// launcher presents its response.
// ============================================================================
module tb_fsm_launcher;

    localparam int N_W   = 8;
    localparam int CYC_W = 16;
    localparam int TO    = 8;

    typedef struct packed {
        logic [N_W-1:0]   jobs;
        logic [CYC_W-1:0] cycles;
        logic             to;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [N_W-1:0]   req_count = '0;
    logic             start;
    logic             busy;
    logic             s_busy = 1'b0;
    logic             w_busy = 1'b0;
    logic             w_done = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [N_W-1:0]   rsp_jobs;
    logic [CYC_W-1:0] rsp_cycles;
    logic             rsp_timeout;

    assign busy = w_busy | s_busy;

    fsm_launcher #(
        .TIMEOUT_CYCLES (TO),
        .N_W            (N_W),
        .CYC_W          (CYC_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_count_i   (req_count),
        .start_o       (start),
        .busy_i        (busy),
        .done_i        (w_done),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_jobs_o    (rsp_jobs),
        .rsp_cycles_o  (rsp_cycles),
        .rsp_timeout_o (rsp_timeout)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Start-pulse monitor: records the cycle of every pulse and counts
    // pulses seen while busy or on two consecutive cycles.
    int   start_times[$];
    int   viol = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (start === 1'b1) start_times.push_back(cyc);
        viol       <= viol + int'(start && busy) + int'(start && prev_start);
        prev_start <= start;
    end

    // Worker: after a start in cycle n, busy in n+1..n+k-1, done in n+k.
    int   worker_k  = 6;
    logic worker_en = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (start === 1'b1 && worker_en) begin
                @(posedge clk); #1;
                for (int j = 1; j < worker_k; j++) begin
                    w_busy = 1'b1;
                    @(posedge clk); #1;
                end
                w_busy = 1'b0;
                w_done = 1'b1;
                @(posedge clk); #1;
                w_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not reach its end");
        $fatal(1, "bench time limit");
    end

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a request; returns the accept cycle. Called and returns at
    // 1 time unit after a rising edge.
    task automatic send_req(input logic [N_W-1:0] cnt, input bit push,
                            input int ej, input int ec, input bit et, output int acc);
        int   n;
        exp_t e;
        req_count = cnt;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        check("req_accept", 32'(req_ready), 32'd1);
        if (push) begin
            e.jobs   = N_W'(ej);
            e.cycles = CYC_W'(ec);
            e.to     = et;
            exp_q.push_back(e);
        end
        $display("req count=%0d accepted at cycle %0d", cnt, acc);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, optionally back-pressure it for 'hold' cycles,
    // and compare against the head of the scoreboard.
    task automatic get_rsp(input string tag, input int hold);
        exp_t e;
        int   n;
        rsp_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (rsp_valid !== 1'b1) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            return;
        end
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"},   32'(rsp_valid),   32'd1);
            check({tag, "_hold_jobs"},    32'(rsp_jobs),    32'(e.jobs));
            check({tag, "_hold_cycles"},  32'(rsp_cycles),  32'(e.cycles));
            check({tag, "_hold_timeout"}, 32'(rsp_timeout), 32'(e.to));
            check({tag, "_hold_reqrdy"},  32'(req_ready),   32'd0);
            @(posedge clk); #1;
            if (i == hold - 1) rsp_ready = 1'b1;
            @(negedge clk);
        end
        $display("rsp %s: jobs=%0d cycles=%0d timeout=%0d", tag, rsp_jobs, rsp_cycles, rsp_timeout);
        check({tag, "_jobs"},    32'(rsp_jobs),    32'(e.jobs));
        check({tag, "_cycles"},  32'(rsp_cycles),  32'(e.cycles));
        check({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.to));
        check({tag, "_hs_reqrdy"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_after_valid"},  32'(rsp_valid), 32'd0);
        check({tag, "_after_reqrdy"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int b;
        int n;
        int nv;

        // Reset for 3 cycles
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",   32'(req_ready),   32'd1);
        check("rst_start",       32'(start),       32'd0);
        check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst_rsp_jobs",    32'(rsp_jobs),    32'd0);
        check("rst_rsp_cycles",  32'(rsp_cycles),  32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic single launch, k=6
        b = start_times.size();
        send_req(8'd1, 1'b1, 1, 7, 1'b0, acc);
        get_rsp("basic", 0);
        check("basic_nstarts", 32'(start_times.size() - b), 32'd1);
        check("basic_start_lat", 32'(start_times[b] - acc), 32'd1);

        // Three launches, k=6 each
        b = start_times.size();
        send_req(8'd3, 1'b1, 3, 23, 1'b0, acc);
        get_rsp("multi", 0);
        check("multi_nstarts", 32'(start_times.size() - b), 32'd3);
        check("multi_start_lat", 32'(start_times[b] - acc), 32'd1);
        check("multi_space1", 32'(start_times[b+1] - start_times[b]), 32'd8);
        check("multi_space2", 32'(start_times[b+2] - start_times[b+1]), 32'd8);
        check("multi_start_rules", 32'(viol), 32'd0);

        // Busy stall of 4 cycles in START
        b = start_times.size();
        s_busy = 1'b1;
        send_req(8'd1, 1'b1, 1, 11, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1 s_busy = 1'b0;
        get_rsp("stall", 0);
        check("stall_start_lat", 32'(start_times[b] - acc), 32'd5);

        // Worker never answers: watchdog expires
        worker_en = 1'b0;
        send_req(8'd1, 1'b1, 0, 9, 1'b1, acc);
        get_rsp("timeout", 0);
        worker_en = 1'b1;

        // done on the last watchdog cycle still counts
        worker_k = 8;
        send_req(8'd1, 1'b1, 1, 9, 1'b0, acc);
        get_rsp("done_at_limit", 0);
        worker_k = 6;

        // Zero count with 5 cycles of response back-pressure
        send_req(8'd0, 1'b1, 0, 0, 1'b0, acc);
        get_rsp("zero_bp", 5);

        // Reset during WAIT_DONE of launch 2 of 3
        b = start_times.size();
        send_req(8'd3, 1'b0, 0, 0, 1'b0, acc);
        n = 0;
        while (start_times.size() < b + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_second_start", 32'(start_times.size() >= b + 2), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rstmid_req_ready",   32'(req_ready),   32'd1);
        check("rstmid_start",       32'(start),       32'd0);
        check("rstmid_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rstmid_rsp_jobs",    32'(rsp_jobs),    32'd0);
        check("rstmid_rsp_cycles",  32'(rsp_cycles),  32'd0);
        check("rstmid_rsp_timeout", 32'(rsp_timeout), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) nv++;
        end
        check("rstmid_no_rsp", 32'(nv), 32'd0);
        check("rstmid_jobs_after_stray_done", 32'(rsp_jobs), 32'd0);
        @(posedge clk); #1;

        // Fresh run after reset, with 3 cycles of back-pressure
        b = start_times.size();
        send_req(8'd1, 1'b1, 1, 7, 1'b0, acc);
        get_rsp("post_reset", 3);
        check("post_reset_start_lat", 32'(start_times[b] - acc), 32'd1);
        check("final_start_rules", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
